// File: rtl/mcu_link_initiator_if.sv
// -----------------------------------------------------------------------------
// mcu_link_initiator_if
// Command / payload / response bundle between a local command issuer and the
// MCU link initiator.
//
// Handshake rules (both channels): a transfer happens on the rising edge where
// valid && ready are both high. The producer holds the payload stable while
// valid is high and may not withdraw valid before the transfer. ready may
// depend on valid: o_data_ready is only raised in the cycle the byte is
// actually taken.
//
// Signals:
//   i_cmd / i_cmd_valid / o_cmd_ready             command channel
//   i_data / i_data_valid / i_data_last / o_data_ready   payload channel
//   o_status / o_status_valid                     GET_STATUS response
//   o_timeout, o_vsync, o_interrupt               one-cycle event pulses
//   o_busy                                        initiator not idle
// Modports: master = command issuer, slave = link initiator.
// -----------------------------------------------------------------------------
interface mcu_link_initiator_if;
    logic [7:0] i_cmd;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       i_data_last;
    logic       o_data_ready;
    logic [7:0] o_status;
    logic       o_status_valid;
    logic       o_timeout;
    logic       o_vsync;
    logic       o_interrupt;
    logic       o_busy;

    modport master (
        output i_cmd, i_cmd_valid, i_data, i_data_valid, i_data_last,
        input  o_cmd_ready, o_data_ready, o_status, o_status_valid,
               o_timeout, o_vsync, o_interrupt, o_busy
    );

    modport slave (
        input  i_cmd, i_cmd_valid, i_data, i_data_valid, i_data_last,
        output o_cmd_ready, o_data_ready, o_status, o_status_valid,
               o_timeout, o_vsync, o_interrupt, o_busy
    );
endinterface

// File: rtl/mcu_link_initiator.sv
// -----------------------------------------------------------------------------
// mcu_link_initiator
// Host end of the MCU UART command link. Frames a command as
// START, CMD, escaped payload, END and shifts it out 8N1 on o_uart_tx.
// Deserialises i_uart_rx, decodes the GET_STATUS (0x00) response and pulses on
// unsolicited VSYNC / INTERRUPT tokens.
//
// Ports:
//   i_master_clk  master clock, everything on its rising edge
//   i_reset       synchronous active-high reset
//   o_uart_tx     UART TX, idle high
//   i_uart_rx     UART RX, asynchronous to i_master_clk
//   link          command/payload/response bundle (slave modport)
//   o_dbg_state   {parser[2:0], rx[1:0], tx[2:0]} FSM states for observation
// -----------------------------------------------------------------------------
module mcu_link_initiator #(
    parameter int CLOCK_FREQ     = 12000000,
    parameter int BOUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                 i_master_clk,
    input  logic                 i_reset,
    output logic                 o_uart_tx,
    input  logic                 i_uart_rx,
    mcu_link_initiator_if.slave  link,
    output logic [7:0]           o_dbg_state
);
    localparam int BIT_CYCLES  = CLOCK_FREQ / BOUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES + 1);
    localparam int TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] TOK_START = 8'hF0;
    localparam logic [7:0] TOK_END   = 8'hF1;
    localparam logic [7:0] TOK_VSYNC = 8'hF2;
    localparam logic [7:0] TOK_INT   = 8'hF3;
    localparam logic [7:0] TOK_ESC   = 8'hF4;

    function automatic logic is_token(input logic [7:0] b);
        return (b >= TOK_START) && (b <= TOK_ESC);
    endfunction

    // ------------------------------------------------------------------ TX byte serialiser
    logic          tx_load;
    logic [7:0]    tx_load_byte;
    logic          tx_busy;
    logic [8:0]    tx_shift;      // data bits then stop bit, LSB goes out next
    logic [3:0]    tx_bit;        // 0 = start, 1..8 = data, 9 = stop
    logic [CW-1:0] tx_cnt;
    logic          tx_done;
    logic          tx_free;

    assign tx_done = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
    // A new byte may be loaded on the last stop-bit cycle so frames run gap-free.
    assign tx_free = !tx_busy || tx_done;

    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            tx_busy   <= 1'b0;
            o_uart_tx <= 1'b1;
            tx_shift  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
        end else if (tx_load) begin
            tx_busy   <= 1'b1;
            o_uart_tx <= 1'b0;
            tx_shift  <= {1'b1, tx_load_byte};
            tx_bit    <= '0;
            tx_cnt    <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy   <= 1'b0;
                    o_uart_tx <= 1'b1;
                end else begin
                    o_uart_tx <= tx_shift[0];
                    tx_shift  <= {1'b1, tx_shift[8:1]};
                    tx_bit    <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------ TX frame FSM
    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND_START, ST_SEND_CMD, ST_SEND_DATA,
        ST_SEND_ESC, ST_SEND_END, ST_WAIT_RESP
    } tx_state_t;

    tx_state_t     tx_state, tx_state_nxt;
    logic [7:0]    cmd_q;
    logic [7:0]    esc_q;
    logic          last_q;
    logic          end_sent;
    logic [TW-1:0] to_cnt;
    logic          to_expire;
    logic          status_hit;
    logic          data_take;

    assign to_expire = (tx_state == ST_WAIT_RESP) && (to_cnt == TO_LAST);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_load_byte = 8'h00;
        data_take    = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (link.i_cmd_valid) tx_state_nxt = ST_SEND_START;
            end
            ST_SEND_START: begin
                if (tx_free) begin
                    tx_load      = 1'b1;
                    tx_load_byte = TOK_START;
                    tx_state_nxt = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (tx_free) begin
                    tx_load      = 1'b1;
                    tx_load_byte = cmd_q;
                    tx_state_nxt = (cmd_q == 8'h00) ? ST_SEND_END : ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (tx_free && link.i_data_valid) begin
                    data_take = 1'b1;
                    tx_load   = 1'b1;
                    if (is_token(link.i_data)) begin
                        tx_load_byte = TOK_ESC;
                        tx_state_nxt = ST_SEND_ESC;
                    end else begin
                        tx_load_byte = link.i_data;
                        if (link.i_data_last) tx_state_nxt = ST_SEND_END;
                    end
                end
            end
            ST_SEND_ESC: begin
                if (tx_free) begin
                    tx_load      = 1'b1;
                    tx_load_byte = esc_q;
                    tx_state_nxt = last_q ? ST_SEND_END : ST_SEND_DATA;
                end
            end
            ST_SEND_END: begin
                // Load END, then stay until its stop bit has fully gone out.
                if (!end_sent) begin
                    if (tx_free) begin
                        tx_load      = 1'b1;
                        tx_load_byte = TOK_END;
                    end
                end else if (tx_done) begin
                    tx_state_nxt = (cmd_q == 8'h00) ? ST_WAIT_RESP : ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                if (status_hit || to_expire) tx_state_nxt = ST_IDLE;
            end
            default: tx_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            tx_state  <= ST_IDLE;
            cmd_q     <= 8'h00;
            esc_q     <= 8'h00;
            last_q    <= 1'b0;
            end_sent  <= 1'b0;
            to_cnt    <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == ST_IDLE && link.i_cmd_valid) cmd_q <= link.i_cmd;
            if (data_take) begin
                esc_q  <= link.i_data ^ 8'h20;
                last_q <= link.i_data_last;
            end
            if (tx_state_nxt != ST_SEND_END)              end_sent <= 1'b0;
            else if (tx_state == ST_SEND_END && tx_load)  end_sent <= 1'b1;
            // Zero on the entry cycle, so expiry lands TIMEOUT_CYCLES after entry.
            if (tx_state != ST_WAIT_RESP) to_cnt <= '0;
            else                          to_cnt <= to_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------ RX deserialiser
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_state_nxt;
    logic [1:0]    rx_sync;
    logic          rx_prev;
    logic          rx_line;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tick;
    logic          rx_done;

    assign rx_line = rx_sync[1];
    assign rx_tick = (rx_cnt == BIT_LAST);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_done      = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_line) rx_state_nxt = RX_START;
            // Half-bit recheck rejects glitches shorter than half a bit.
            RX_START: if (rx_cnt == HALF_LAST) rx_state_nxt = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_nxt = RX_IDLE;
                    rx_done      = rx_line;   // framing error drops the byte
                end
            end
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            rx_state <= RX_IDLE;
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= 8'h00;
        end else begin
            rx_sync  <= {rx_sync[0], i_uart_rx};
            rx_prev  <= rx_line;
            rx_state <= rx_state_nxt;
            case (rx_state)
                RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? '0 : rx_cnt + CW'(1);
                RX_DATA, RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        if (rx_state == RX_DATA) begin
                            rx_shift <= {rx_line, rx_shift[7:1]};
                            rx_bit   <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX response parser
    typedef enum logic [2:0] {P_HUNT, P_CMD, P_STAT, P_ESC, P_END} prs_state_t;

    prs_state_t p_state, p_state_nxt;
    logic [7:0] stat_q;
    logic [7:0] stat_nxt;
    logic       stat_load;
    logic       rx_is_event;
    logic       bad_nxt_cmd;   // restart on START, otherwise hunt

    assign rx_is_event = (rx_shift == TOK_VSYNC) || (rx_shift == TOK_INT);
    assign bad_nxt_cmd = (rx_shift == TOK_START);

    always_comb begin
        p_state_nxt = p_state;
        status_hit  = 1'b0;
        stat_load   = 1'b0;
        stat_nxt    = rx_shift;
        if (tx_state != ST_WAIT_RESP) begin
            p_state_nxt = P_HUNT;
        end else if (rx_done && !rx_is_event) begin
            // Event tokens are transparent to the frame; everything else advances it.
            case (p_state)
                P_HUNT: if (rx_shift == TOK_START) p_state_nxt = P_CMD;
                P_CMD: begin
                    if (rx_shift == 8'h00) p_state_nxt = P_STAT;
                    else                   p_state_nxt = bad_nxt_cmd ? P_CMD : P_HUNT;
                end
                P_STAT: begin
                    if (rx_shift == TOK_ESC) begin
                        p_state_nxt = P_ESC;
                    end else if (is_token(rx_shift)) begin
                        p_state_nxt = bad_nxt_cmd ? P_CMD : P_HUNT;
                    end else begin
                        stat_load   = 1'b1;
                        p_state_nxt = P_END;
                    end
                end
                P_ESC: begin
                    if (is_token(rx_shift)) begin
                        p_state_nxt = bad_nxt_cmd ? P_CMD : P_HUNT;
                    end else begin
                        stat_load   = 1'b1;
                        stat_nxt    = rx_shift ^ 8'h20;
                        p_state_nxt = P_END;
                    end
                end
                P_END: begin
                    if (rx_shift == TOK_END) begin
                        status_hit  = 1'b1;
                        p_state_nxt = P_HUNT;
                    end else begin
                        p_state_nxt = bad_nxt_cmd ? P_CMD : P_HUNT;
                    end
                end
                default: p_state_nxt = P_HUNT;
            endcase
        end
    end

    logic [7:0] status_r;
    logic       status_valid_r;
    logic       timeout_r;
    logic       vsync_r;
    logic       interrupt_r;

    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            p_state        <= P_HUNT;
            stat_q         <= 8'h00;
            status_r       <= 8'h00;
            status_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
            vsync_r        <= 1'b0;
            interrupt_r    <= 1'b0;
        end else begin
            p_state        <= p_state_nxt;
            if (stat_load)  stat_q   <= stat_nxt;
            if (status_hit) status_r <= stat_q;
            status_valid_r <= status_hit;
            // A valid END on the expiry cycle takes priority over the timeout.
            timeout_r      <= to_expire && !status_hit;
            vsync_r        <= rx_done && (rx_shift == TOK_VSYNC);
            interrupt_r    <= rx_done && (rx_shift == TOK_INT);
        end
    end

    // ------------------------------------------------------------------ outputs
    assign link.o_cmd_ready    = (tx_state == ST_IDLE);
    assign link.o_busy         = (tx_state != ST_IDLE);
    assign link.o_data_ready   = data_take;
    assign link.o_status       = status_r;
    assign link.o_status_valid = status_valid_r;
    assign link.o_timeout      = timeout_r;
    assign link.o_vsync        = vsync_r;
    assign link.o_interrupt    = interrupt_r;
    assign o_dbg_state         = {p_state, rx_state, tx_state};

endmodule

// File: doc/mcu_link_initiator.md
Name: mcu_link_initiator

Overview:
Host end of the MCU UART command link. It frames local commands as START, CMD, escaped payload and END, then serialises them 8N1 on o_uart_tx. It deserialises i_uart_rx, returns the GET_STATUS (0x00) response byte, and pulses on unsolicited VSYNC and INTERRUPT tokens. It is used as the MCU-side model on the bench and as the bridge in the debug build.

Parameters:
CLOCK_FREQ, 12000000, master clock in Hz
BOUD_RATE, 115200, line rate; bit period = CLOCK_FREQ/BOUD_RATE cycles, truncated (104 at defaults)
TIMEOUT_CYCLES, 1200000, cycles from END sent to response abandoned (100 ms at defaults)

Ports:
i_master_clk  in  1  master clock; all logic on its rising edge
i_reset  in  1  synchronous, active-high reset
o_uart_tx  out  1  UART TX, idle high
i_uart_rx  in  1  UART RX, asynchronous
i_cmd  in  8  command code
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  high only in IDLE
i_data  in  8  payload byte
i_data_valid  in  1  payload byte valid
i_data_last  in  1  marks final payload byte
o_data_ready  out  1  payload byte accepted this cycle
o_status  out  8  last received status byte
o_status_valid  out  1  one-cycle pulse
o_timeout  out  1  one-cycle pulse, no valid response
o_vsync  out  1  one-cycle pulse per VSYNC token
o_interrupt  out  1  one-cycle pulse per INTERRUPT token
o_busy  out  1  high outside IDLE

Behaviour:
- Clocking and reset: one clock (i_master_clk); reset is synchronous and active-high (i_reset).
- Reset values: o_uart_tx=1, o_status=0x00, and all pulses, o_data_ready and o_busy are 0. o_cmd_ready=1 on the first cycle after reset.
- Reset mid-operation: o_uart_tx returns high immediately, which truncates the byte in flight; the FPGA side resyncs on the next START. RX shifter and parser clear, and no pulses are emitted.
- Tokens: START=0xF0, END=0xF1, VSYNC=0xF2, INTERRUPT=0xF3, ESC=0xF4.
- Escaping: a payload byte or status byte in 0xF0..0xF4 is sent as ESC followed by (byte XOR 0x20). CMD bytes are never escaped; valid command codes are below 0xF0.
- Command handshake: the command is accepted when i_cmd_valid && o_cmd_ready. i_cmd is latched, and o_cmd_ready drops the next cycle.
- TX FSM states: IDLE, SEND_START, SEND_CMD, SEND_DATA, SEND_ESC, SEND_END, WAIT_RESP.
  - IDLE -> SEND_START on accept.
  - SEND_START -> SEND_CMD, once the byte serialiser has finished START.
  - SEND_CMD -> SEND_END if cmd==0x00; otherwise -> SEND_DATA.
  - SEND_DATA: the serialiser is free and i_data_valid=1 -> o_data_ready pulses for one cycle and the byte is latched. An escapable byte goes through SEND_ESC (ESC, then transformed byte). i_data_last on the accepted byte -> SEND_END after it is sent.
  - SEND_END -> WAIT_RESP if cmd==0x00; otherwise -> IDLE.
  - WAIT_RESP -> IDLE on status capture or timeout.
- Payload length is caller responsibility: 0x07 takes 1 byte, 0x03 takes 3 bytes, 0x01 and 0x02 are unbounded.
- Serialiser: start bit, LSB-first data, 1 stop bit. Back-to-back bytes carry no idle gap.
- RX path:
  - i_uart_rx passes a 2-FF synchroniser.
  - Falling edge while idle starts a byte; the start bit is re-checked at half-bit and data bits are sampled mid-bit.
  - Start-bit glitch -> return to idle.
  - Stop bit = 0 -> byte dropped.
- RX parser:
  - VSYNC or INTERRUPT anywhere pulses o_vsync or o_interrupt one cycle after the stop-bit sample. This applies during TX and inside a response frame, and the frame state is not disturbed.
  - In WAIT_RESP the parser expects START, 0x00, status (ESC-decoded), END.
  - On END, o_status updates and o_status_valid pulses in the same cycle.
  - Any mismatch -> parser returns to hunting START; the timeout keeps running.
  - Response bytes outside WAIT_RESP are ignored.
- Timeout: the counter starts on the cycle WAIT_RESP is entered. After TIMEOUT_CYCLES with no valid response, o_timeout pulses and the FSM returns to IDLE; o_status is unchanged. A valid END on the same cycle as expiry wins: status is reported and no timeout pulse is emitted.
- New commands are never accepted outside IDLE.

Test Plan:
- Cmd 0x07 with payload 0x02 (last) -> line carries F0 07 02 F1, 1040 cycles/byte at defaults; o_cmd_ready returns 1 after the END stop bit.
- Cmd 0x03 with payload 0x01, 0xF2, 0x10 -> line carries F0 03 01 F4 D2 10 F1; o_data_ready pulses exactly 3 times.
- Cmd 0x00, then RX F0 00 F4 D3 F1 -> o_status=0xF3 with a single o_status_valid pulse; no o_interrupt pulse.
- Cmd 0x00 with no reply, TIMEOUT_CYCLES=5000 -> o_timeout pulses exactly 5000 cycles after WAIT_RESP entry; o_status retains 0x00.
- RX 0xF2 injected mid-transmit, plus one RX byte with a forced stop bit of 0 -> exactly one o_vsync pulse; the bad byte produces no output.
- i_reset asserted mid-payload -> o_uart_tx=1 the next cycle, o_busy=0, o_cmd_ready=1; the next command is framed correctly.
